// File: rtl/alu_mul_seq_if.sv
// Bus between the control unit / shared ALU and the shift-and-add multiply sequencer.
// MULSEQ_SIGNED_EN adds the signed_op request qualifier.
interface alu_mul_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        prod_z;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_f;
`ifdef MULSEQ_SIGNED_EN
  logic        signed_op;

  modport slave (
    input  start, a, b, signed_op, alu_f,
    output busy, done, product, prod_z, alu_a, alu_b, alu_op
  );
  modport master (
    output start, a, b, signed_op, alu_f,
    input  busy, done, product, prod_z, alu_a, alu_b, alu_op
  );
`else
  modport slave (
    input  start, a, b, alu_f,
    output busy, done, product, prod_z, alu_a, alu_b, alu_op
  );
  modport master (
    output start, a, b, alu_f,
    input  busy, done, product, prod_z, alu_a, alu_b, alu_op
  );
`endif
endinterface

// File: rtl/alu_mul_seq.sv
// 16x16->32 unsigned shift-and-add multiplier that borrows the shared 16-bit ALU adder.
// MULSEQ_SIGNED_EN: optional sign-magnitude signed multiply with an extra FIX state.
module alu_mul_seq (
  input logic          clk,
  input logic          rst,
  alu_mul_seq_if.slave bus
);
  localparam int unsigned W    = 16;
  localparam int unsigned PW   = 32;
  localparam int unsigned CW   = 5;
  localparam int unsigned ITER = 16;
  localparam logic [3:0]  OP_ADD = 4'b0001;
  localparam logic [3:0]  OP_NOP = 4'b0000;

`ifdef MULSEQ_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_FIX} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
`endif

  state_e          state_q, state_d;
  logic [W-1:0]    m_q, m_d;
  logic [W-1:0]    ph_q, ph_d;
  logic [W-1:0]    pl_q, pl_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   product_q, product_d;
  logic            prod_z_q, prod_z_d;
`ifdef MULSEQ_SIGNED_EN
  logic            sign_q, sign_d;
  logic [PW-1:0]   fix_c;
`endif

  logic [W-1:0]    alu_a_c;
  logic [W-1:0]    alu_b_c;
  logic [3:0]      alu_op_c;
  logic            carry_c;
  logic [PW-1:0]   shift_c;
  logic [W-1:0]    ld_a_c;
  logic [W-1:0]    ld_b_c;
  logic            ld_sign_c;

  // ALU drive is a pure function of the registers
  always_comb begin
    alu_a_c  = '0;
    alu_b_c  = '0;
    alu_op_c = OP_NOP;
    if (state_q == S_CALC) begin
      alu_a_c  = ph_q;
      alu_b_c  = pl_q[0] ? m_q : '0;
      alu_op_c = OP_ADD;
    end
  end

  assign bus.alu_a  = alu_a_c;
  assign bus.alu_b  = alu_b_c;
  assign bus.alu_op = alu_op_c;

  // Carry out of the ALU add recovered from operand and result MSBs
  assign carry_c = (alu_a_c[W-1] & alu_b_c[W-1])
                 | ((alu_a_c[W-1] | alu_b_c[W-1]) & ~bus.alu_f[W-1]);
  assign shift_c = {carry_c, bus.alu_f, pl_q[W-1:1]};

`ifdef MULSEQ_SIGNED_EN
  assign fix_c = sign_q ? PW'(~{ph_q, pl_q} + PW'(1)) : {ph_q, pl_q};
`endif

  // Operand capture; signed mode loads magnitudes (0x8000 stays 0x8000)
  always_comb begin
    ld_a_c    = bus.a;
    ld_b_c    = bus.b;
    ld_sign_c = 1'b0;
`ifdef MULSEQ_SIGNED_EN
    if (bus.signed_op) begin
      ld_a_c    = bus.a[W-1] ? W'(~bus.a + W'(1)) : bus.a;
      ld_b_c    = bus.b[W-1] ? W'(~bus.b + W'(1)) : bus.b;
      ld_sign_c = bus.a[W-1] ^ bus.b[W-1];
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    ph_d      = ph_q;
    pl_d      = pl_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    prod_z_d  = prod_z_q;
`ifdef MULSEQ_SIGNED_EN
    sign_d    = sign_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          m_d     = ld_a_c;
          ph_d    = '0;
          pl_d    = ld_b_c;
          cnt_d   = '0;
`ifdef MULSEQ_SIGNED_EN
          sign_d  = ld_sign_c;
`endif
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        {ph_d, pl_d} = shift_c;
        cnt_d        = CW'(cnt_q + CW'(1));
        if (cnt_q == CW'(ITER - 1)) begin
`ifdef MULSEQ_SIGNED_EN
          state_d = S_FIX;
`else
          state_d   = S_DONE;
          product_d = shift_c;
          prod_z_d  = (shift_c == '0);
`endif
        end
      end
`ifdef MULSEQ_SIGNED_EN
      S_FIX: begin
        {ph_d, pl_d} = fix_c;
        product_d    = fix_c;
        prod_z_d     = (fix_c == '0);
        state_d      = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

`ifndef MULSEQ_SIGNED_EN
  logic unused_c;
  assign unused_c = ld_sign_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      ph_q      <= '0;
      pl_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      prod_z_q  <= 1'b0;
`ifdef MULSEQ_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      ph_q      <= ph_d;
      pl_q      <= pl_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      prod_z_q  <= prod_z_d;
`ifdef MULSEQ_SIGNED_EN
      sign_q    <= sign_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.prod_z  = prod_z_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed and random multiplies against an arithmetic model.
module tb_alu_mul_seq;
`ifdef MULSEQ_SIGNED_EN
  localparam int unsigned LAT = 18;
`else
  localparam int unsigned LAT = 17;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_mul_seq_if bus ();

  alu_mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU model: add on OP_ADD, zero on NOP
  assign bus.alu_f = (bus.alu_op == 4'b0001) ? 16'(bus.alu_a + bus.alu_b) : 16'h0;

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input bit s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({48'h0, a});
      sb = longint'({48'h0, b});
    end
    return 32'(sa * sb);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b, input bit s);
    bus.a = a;
    bus.b = b;
`ifdef MULSEQ_SIGNED_EN
    bus.signed_op = s;
`else
    if (s) $display("note: signed request ignored in unsigned build");
`endif
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit s);
    @(negedge clk);
    bus.start = 1'b1;
    set_ops(a, b, s);
  endtask

  // Walks one operation from the cycle after acceptance through its done cycle
  task automatic collect(input string tag, input logic [31:0] exp_p, input bit pulses,
                         input bit zero_b, input bit chain,
                         input logic [15:0] na, input logic [15:0] nb, input bit ns);
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk);
      if (k < int'(LAT)) begin
        bus.start = pulses && (k == 5 || k == 10);
        if (bus.start) set_ops(16'($urandom), 16'($urandom), 1'b0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_done_early"}, 32'(bus.done), 32'd0);
        if (k <= 16) check({tag, "_alu_op"}, 32'(bus.alu_op), 32'd1);
        if (zero_b && k <= 16) check({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
      end else begin
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_product"}, bus.product, exp_p);
        check({tag, "_prod_z"}, 32'(bus.prod_z), 32'(exp_p == 32'h0));
        bus.start = chain;
        if (chain) set_ops(na, nb, ns);
      end
    end
  endtask

  initial begin
    logic [15:0] ra, rb, nra, nrb;
    bit          rs, nrs, ch, pending;
    bit          done_seen;

    rst       = 1'b1;
    bus.start = 1'b0;
    set_ops(16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy",    32'(bus.busy),   32'd0);
    check("rst_done",    32'(bus.done),   32'd0);
    check("rst_product", bus.product,     32'd0);
    check("rst_prod_z",  32'(bus.prod_z), 32'd0);
    check("rst_alu_op",  32'(bus.alu_op), 32'd0);
    check("rst_alu_a",   32'(bus.alu_a),  32'd0);
    check("rst_alu_b",   32'(bus.alu_b),  32'd0);
    rst = 1'b0;

    issue(16'd3, 16'd5, 1'b0);
    collect("m3x5", 32'h0000000F, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    issue(16'hFFFF, 16'hFFFF, 1'b0);
    collect("mffff", 32'hFFFE0001, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    issue(16'h0000, 16'h1234, 1'b0);
    collect("mzero", 32'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);

    issue(16'd7, 16'd9, 1'b0);
    collect("m7x9", 32'd63, 1'b1, 1'b0, 1'b1, 16'd2, 16'h8000, 1'b0);
    collect("b2b", 32'h00010000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

`ifdef MULSEQ_SIGNED_EN
    issue(16'hFFFD, 16'd5, 1'b1);
    collect("s_m3x5", 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    issue(16'h8000, 16'h8000, 1'b1);
    collect("s_min", 32'h40000000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
`endif

    ra = 16'($urandom);
    rb = 16'($urandom);
`ifdef MULSEQ_SIGNED_EN
    rs = (($urandom & 1) == 1);
`else
    rs = 1'b0;
`endif
    pending = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!pending) issue(ra, rb, rs);
      nra = 16'($urandom);
      nrb = 16'($urandom);
`ifdef MULSEQ_SIGNED_EN
      nrs = (($urandom & 1) == 1);
`else
      nrs = 1'b0;
`endif
      ch = (i < 15) && (($urandom & 1) == 1);
      collect("rand", model(ra, rb, rs), 1'b0, 1'b0, ch, nra, nrb, nrs);
      ra = nra;
      rb = nrb;
      rs = nrs;
      pending = ch;
    end

    issue(16'h1234, 16'h5678, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",    32'(bus.busy),   32'd0);
    check("mid_rst_done",    32'(bus.done),   32'd0);
    check("mid_rst_product", bus.product,     32'd0);
    check("mid_rst_prod_z",  32'(bus.prod_z), 32'd0);
    check("mid_rst_alu_op",  32'(bus.alu_op), 32'd0);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    check("mid_rst_no_done", 32'(done_seen), 32'd0);

    issue(16'd3, 16'd5, 1'b0);
    collect("post_rst", 32'h0000000F, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
